// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM state encoding and
// a constant-evaluable ceil(log2) used to size the lane index.
package fifo_rd_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_OUT  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_lane_dec.sv
// Lane write decoder: turns the next-lane index into a one-hot write enable.
module fifo_rd_packer_lane_dec #(
  parameter int PACK  = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [PACK-1:0]  lane_en_o
);

  // One-hot decode of the lane index
  always_comb begin
    lane_en_o        = '0;
    lane_en_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: packs PACK show-ahead entries into
// one wide word on a valid/ready stream, with flush of a partial word.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       RCLK,
  input  logic                       RRST,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       read,
  input  logic                       flush,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_WIDTH-1:0]       words_out
);

  localparam int                IDX_W    = clog2(PACK);
  localparam int                OUT_W    = PACK * DATA_WIDTH;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PACK - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OUT_W-1:0]       data_q, data_d;
  logic [PACK-1:0]        keep_q, keep_d;
  logic [CNT_WIDTH-1:0]   words_q, words_d;
  logic [PACK-1:0]        lane_en_s;

  fifo_rd_packer_lane_dec #(
    .PACK  (PACK),
    .IDX_W (IDX_W)
  ) u_lane_dec (
    .idx_i     (idx_q),
    .lane_en_o (lane_en_s)
  );

  // Next-state, accumulator update and pop strobe
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    keep_d  = keep_q;
    words_d = words_q;
    read    = 1'b0;
    case (state_q)
      ST_FILL: begin
        // A flush with lanes pending takes priority over popping a new entry.
        if (flush && (idx_q != '0)) begin
          state_d = ST_OUT;
          idx_d   = '0;
        end else if (!empty && !RRST) begin
          read = 1'b1;
          for (int i = 0; i < PACK; i++) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_en_s[i] ? rdata
                                               : data_q[i*DATA_WIDTH +: DATA_WIDTH];
            keep_d[i] = keep_q[i] | lane_en_s[i];
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_OUT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          words_d = words_q + CNT_WIDTH'(1);
          data_d  = '0;
          keep_d  = '0;
          state_d = ST_FILL;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge RCLK or posedge RRST) begin
    if (RRST) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      words_q <= words_d;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = (state_q == ST_OUT);
  assign words_out = words_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It drains `DATA_WIDTH`-bit entries via the FIFO's `read`/`empty`/`rdata` port. It packs `PACK` consecutive entries into one wide word and presents that word on a valid/ready stream, with a flush input that emits a partially filled word.

## Interface
Parameters:
- `DATA_WIDTH`, 8: FIFO entry width.
- `PACK`, 4: entries per output word; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the emitted-word counter.

Ports:
- `RCLK`  in  1: read-domain clock; all logic is on its rising edge.
- `RRST`  in  1: asynchronous, active-high reset.
- `empty`  in  1: FIFO empty flag.
- `rdata`  in  DATA_WIDTH: FIFO head entry.
  - Show-ahead: valid whenever `empty`=0.
- `read`  out  1: FIFO pop strobe; combinational.
- `flush`  in  1: level-sampled; emit accumulated partial word.
- `out_data`  out  PACK*DATA_WIDTH: packed word; entry 0 in the LSBs.
- `out_keep`  out  PACK: per-lane valid mask; bit i covers lane i.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: downstream accept.
- `words_out`  out  CNT_WIDTH: count of accepted output words.

## Operation
- State machine with two states.
  - FILL: accumulate entries.
  - OUT: hold the word until handshake.
- Internal registers:
  - `idx` (clog2(PACK) bits): next lane to fill.
  - Accumulator: drives `out_data` and `out_keep` directly.
- `read` = FILL && !empty && !(flush && idx≠0) && !RRST.
- Pop in FILL (`read`=1):
  - Store `rdata` into lane `idx` and set `out_keep[idx]`.
  - If `idx`=PACK-1: `idx`←0 and go to OUT, with keep all ones.
  - Otherwise: `idx`←idx+1.
- Flush in FILL:
  - If `idx`≠0: no pop that cycle; go to OUT with keep = lanes 0..idx-1; `idx`←0.
  - If `idx`=0: flush is a no-op and a normal pop may occur.
  - Flush in OUT is ignored; it has no effect on the held word.
- Unfilled lanes carry 0 in `out_data`.
- OUT:
  - `out_valid`=1 and `read`=0.
  - `out_data` and `out_keep` hold stable until `out_ready`=1.
  - On handshake: `words_out`←words_out+1 (wraps modulo 2^CNT_WIDTH); clear `out_data` and `out_keep`; go to FILL.
- `empty`=1 in FILL: no pop; state and lanes hold indefinitely.
- Reset values:
  - State FILL, `idx`=0.
  - `out_data`=0, `out_keep`=0, `out_valid`=0, `words_out`=0.
  - `read`=0 while `RRST` is high.
  - Reset mid-word discards accumulated lanes.

## Timing
- Pop-to-register: an entry popped at edge k is in its lane after edge k.
- Full word: `out_valid` rises after the edge carrying the PACK-th pop.
  - With the FIFO continuously non-empty, the first entry of a word is popped at edge k.
  - `out_valid`=1 from edge k+PACK-1.
- Handshake at edge m: `out_valid`=0 after m; the next pop can occur at edge m+1.
  - Peak throughput: PACK+1 cycles per word when `out_ready` is tied high.
- Flush at edge k (FILL, `idx`≠0): `out_valid`=1 after edge k.
- `read` is combinational from `empty`, `flush` and state; no combinational path from `out_ready` to `read`.

## Structure
- Shared header `fifo_defs.vh` holds:
  - State encodings `ST_FILL`=1'b0, `ST_OUT`=1'b1.
  - Clog2 helper function used for the `idx` width.
- No sub-module required.
  - Optional: `pack_lane_wr` as the lane write-decoder (idx → one-hot enable).
  - All logic otherwise lives in one module instantiated beside `asyn_fifo_top` on `RCLK`.

## Test plan
- Reset with `empty`=0 held: `read`=0 during `RRST`; after release, `out_valid`=0, `words_out`=0, first pop on the next edge.
- Full word, PACK=4, DW=8: feed 0x11,0x22,0x33,0x44 back-to-back with `out_ready`=1 → `out_data`=0x44332211, `out_keep`=4'b1111, `words_out`=1.
- Backpressure: `out_ready`=0 for 10 cycles with the FIFO non-empty.
  - `read` stays 0 and `out_data` is stable for those cycles.
  - Releasing `out_ready` gives one handshake, then popping resumes.
- Partial flush: pop 0xA1,0xB2, then `flush`=1 with `empty`=0.
  - No pop that cycle.
  - Output 0x0000B2A1 with `out_keep`=4'b0011.
- Flush with `idx`=0 and simultaneous non-empty FIFO: a normal pop occurs and no word is emitted.
- Counter wrap with CNT_WIDTH=2: five accepted words → `words_out`=1.
- Stall: `empty` toggles randomly mid-word.
  - Lanes fill in order with no duplicates or skips.
  - Scoreboard matches the FIFO write sequence.
